// File: rtl/dec_stage.sv
// rtl/dec_stage.sv - decode stage with valid/ready handshake, prioritised forwarding and load-use stall
//
// decoder   : combinational RV32I/Zicsr decode of one instruction word.
// dec_stage : ifetch side  if_valid_i/if_ready_o, instr_i, pc_i
//             RF/CSR read  rf_rs*_adr_o/rf_rs*_data_i, csr_adr_o/csr_data_i
//             forwarding   ff_v_i, ff_pending_i, ff_adr_i, ff_data_i (index 0 youngest), csr_ff_*
//             execute side valid_q_o, exe_ready_i, registered payload *_q_o
//             misc         flush_v_i, stall_cnt_o (saturating hazard-stall cycles)

module decoder #(
    parameter int XLEN         = 32,
    parameter int NB_UNIT      = 4,
    parameter int NB_OPERATION = 4
) (
    input  logic [XLEN-1:0]         instr,
    output logic                    rs1_v,
    output logic [4:0]              rs1_adr,
    output logic                    rs2_v,
    output logic [4:0]              rs2_adr,
    output logic                    rd_v,
    output logic [4:0]              rd_adr,
    output logic [11:0]             csr_adr,
    output logic                    csr_wbk,
    output logic                    csr_clear,
    output logic                    csrrw,
    output logic [XLEN-1:0]         imm,
    output logic [1:0]              rs1_sel,
    output logic [1:0]              rs2_sel,
    output logic                    unsign_ext,
    output logic                    rs2_ca2_v,
    output logic [2:0]              access_size,
    output logic [NB_UNIT-1:0]      unit,
    output logic [NB_OPERATION-1:0] operation,
    output logic                    illegal_inst
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // operand source selects, shared with dec_stage
    localparam logic [1:0] SEL_REG = 2'd0;
    localparam logic [1:0] SEL_IMM = 2'd1;
    localparam logic [1:0] SEL_ALT = 2'd2;   // pc for rs1, csr for rs2

    localparam logic [NB_UNIT-1:0] U_ALU = NB_UNIT'(1);
    localparam logic [NB_UNIT-1:0] U_BRU = NB_UNIT'(2);
    localparam logic [NB_UNIT-1:0] U_LSU = NB_UNIT'(4);
    localparam logic [NB_UNIT-1:0] U_CSR = NB_UNIT'(8);

    logic [31:0] ins;
    logic [2:0]  f3;
    logic [31:0] imm32;

    assign ins = instr[31:0];
    assign f3  = ins[14:12];

    always_comb begin
        rs1_v        = 1'b0;
        rs2_v        = 1'b0;
        rd_v         = 1'b0;
        rd_adr       = ins[11:7];
        csr_adr      = 12'h000;
        csr_wbk      = 1'b0;
        csr_clear    = 1'b0;
        csrrw        = 1'b0;
        imm32        = 32'h0;
        rs1_sel      = SEL_REG;
        rs2_sel      = SEL_REG;
        unsign_ext   = 1'b0;
        rs2_ca2_v    = 1'b0;
        access_size  = 3'b000;
        unit         = U_ALU;
        operation    = '0;
        illegal_inst = 1'b0;

        case (ins[6:0])
            OPC_LUI: begin
                rd_v    = 1'b1;
                rs1_sel = SEL_IMM;
                imm32   = {ins[31:12], 12'h000};
            end
            OPC_AUIPC: begin
                rd_v    = 1'b1;
                rs1_sel = SEL_ALT;
                rs2_sel = SEL_IMM;
                imm32   = {ins[31:12], 12'h000};
            end
            OPC_JAL: begin
                rd_v      = 1'b1;
                rs1_sel   = SEL_ALT;
                rs2_sel   = SEL_IMM;
                imm32     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                unit      = U_BRU;
                operation = NB_OPERATION'(8);
            end
            OPC_JALR: begin
                illegal_inst = (f3 != 3'b000);
                rd_v      = 1'b1;
                rs1_v     = 1'b1;
                rs2_sel   = SEL_IMM;
                imm32     = {{20{ins[31]}}, ins[31:20]};
                unit      = U_BRU;
                operation = NB_OPERATION'(9);
            end
            OPC_BRANCH: begin
                illegal_inst = (f3[2:1] == 2'b01);
                rs1_v      = 1'b1;
                rs2_v      = 1'b1;
                imm32      = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                unit       = U_BRU;
                operation  = NB_OPERATION'(f3);
                rs2_ca2_v  = 1'b1;
                unsign_ext = f3[1];
            end
            OPC_LOAD: begin
                illegal_inst = (f3 == 3'b011) || (f3[2:1] == 2'b11);
                rd_v        = 1'b1;
                rs1_v       = 1'b1;
                rs2_sel     = SEL_IMM;
                imm32       = {{20{ins[31]}}, ins[31:20]};
                unit        = U_LSU;
                operation   = NB_OPERATION'(f3);
                unsign_ext  = f3[2];
                access_size = (f3[1:0] == 2'b00) ? 3'b001 : (f3[1:0] == 2'b01) ? 3'b010 : 3'b100;
            end
            OPC_STORE: begin
                illegal_inst = f3[2] || (f3[1:0] == 2'b11);
                rs1_v       = 1'b1;
                rs2_v       = 1'b1;
                imm32       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                unit        = U_LSU;
                operation   = NB_OPERATION'({1'b1, f3});
                access_size = (f3[1:0] == 2'b00) ? 3'b001 : (f3[1:0] == 2'b01) ? 3'b010 : 3'b100;
            end
            OPC_OPIMM: begin
                illegal_inst = ((f3 == 3'b001) && (ins[31:25] != 7'b0)) ||
                               ((f3 == 3'b101) && ({ins[31], ins[29:25]} != 6'b0));
                rd_v       = 1'b1;
                rs1_v      = 1'b1;
                rs2_sel    = SEL_IMM;
                imm32      = {{20{ins[31]}}, ins[31:20]};
                operation  = NB_OPERATION'({(f3 == 3'b101) & ins[30], f3});
                rs2_ca2_v  = (f3[2:1] == 2'b01);
                unsign_ext = (f3 == 3'b011);
            end
            OPC_OP: begin
                illegal_inst = !((ins[31:25] == 7'b0000000) ||
                                 ((ins[31:25] == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
                rd_v       = 1'b1;
                rs1_v      = 1'b1;
                rs2_v      = 1'b1;
                operation  = NB_OPERATION'({ins[30], f3});
                // subtract and set-less-than both need rs1 - rs2
                rs2_ca2_v  = (ins[30] && (f3 == 3'b000)) || (f3[2:1] == 2'b01);
                unsign_ext = (f3 == 3'b011);
            end
            OPC_FENCE: begin
            end
            OPC_SYSTEM: begin
                illegal_inst = (f3[1:0] == 2'b00);
                rd_v       = 1'b1;
                rs1_v      = ~f3[2];
                rs1_sel    = f3[2] ? SEL_IMM : SEL_REG;
                rs2_sel    = SEL_ALT;
                imm32      = {27'b0, ins[19:15]};
                csr_adr    = ins[31:20];
                // set/clear with a zero mask only reads the CSR
                csr_wbk    = (f3[1:0] == 2'b01) || (ins[19:15] != 5'd0);
                csr_clear  = (f3[1:0] == 2'b11);
                csrrw      = (f3[1:0] == 2'b01);
                unsign_ext = 1'b1;
                unit       = U_CSR;
                operation  = NB_OPERATION'(f3);
            end
            default: illegal_inst = 1'b1;
        endcase

        if (illegal_inst) begin
            rd_v    = 1'b0;
            csr_wbk = 1'b0;
            rs1_v   = 1'b0;
            rs2_v   = 1'b0;
        end
    end

    assign rs1_adr = rs1_v ? ins[19:15] : 5'd0;
    assign rs2_adr = rs2_v ? ins[24:20] : 5'd0;
    assign imm     = XLEN'($signed(imm32));
endmodule

module dec_stage #(
    parameter int XLEN  = 32,
    parameter int NB_FF = 2,
    parameter int CNT_W = 16,
    localparam int NB_UNIT      = 4,
    localparam int NB_OPERATION = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    if_valid_i,
    output logic                    if_ready_o,
    input  logic [XLEN-1:0]         instr_i,
    input  logic [XLEN-1:0]         pc_i,
    output logic [4:0]              rf_rs1_adr_o,
    output logic [4:0]              rf_rs2_adr_o,
    input  logic [XLEN-1:0]         rf_rs1_data_i,
    input  logic [XLEN-1:0]         rf_rs2_data_i,
    output logic [11:0]             csr_adr_o,
    input  logic [XLEN-1:0]         csr_data_i,
    input  logic [NB_FF-1:0]        ff_v_i,
    input  logic [NB_FF-1:0]        ff_pending_i,
    input  logic [5*NB_FF-1:0]      ff_adr_i,
    input  logic [XLEN*NB_FF-1:0]   ff_data_i,
    input  logic                    csr_ff_v_i,
    input  logic [11:0]             csr_ff_adr_i,
    input  logic [XLEN-1:0]         csr_ff_data_i,
    input  logic                    exe_ready_i,
    output logic                    valid_q_o,
    output logic [XLEN-1:0]         pc_q_o,
    output logic                    rd_v_q_o,
    output logic [4:0]              rd_adr_q_o,
    output logic                    csr_wbk_q_o,
    output logic [11:0]             csr_adr_q_o,
    output logic [XLEN:0]           rs1_data_q_o,
    output logic [XLEN:0]           rs2_data_q_o,
    output logic [XLEN-1:0]         imm_q_o,
    output logic [2:0]              access_size_q_o,
    output logic                    unsign_ext_q_o,
    output logic                    csrrw_q_o,
    output logic [NB_UNIT-1:0]      unit_q_o,
    output logic [NB_OPERATION-1:0] operation_q_o,
    output logic                    illegal_inst_q_o,
    output logic [CNT_W-1:0]        stall_cnt_o,
    input  logic                    flush_v_i
);
    logic                    rs1_v, rs2_v, rd_v, csr_wbk, csr_clear, csrrw;
    logic [4:0]              rs1_adr, rs2_adr, rd_adr;
    logic [11:0]             csr_adr;
    logic [XLEN-1:0]         imm;
    logic [1:0]              rs1_sel, rs2_sel;
    logic                    unsign_ext, rs2_ca2_v, illegal_inst;
    logic [2:0]              access_size;
    logic [NB_UNIT-1:0]      unit;
    logic [NB_OPERATION-1:0] operation;

    decoder #(
        .XLEN         (XLEN),
        .NB_UNIT      (NB_UNIT),
        .NB_OPERATION (NB_OPERATION)
    ) u_decoder (
        .instr        (instr_i),
        .rs1_v        (rs1_v),
        .rs1_adr      (rs1_adr),
        .rs2_v        (rs2_v),
        .rs2_adr      (rs2_adr),
        .rd_v         (rd_v),
        .rd_adr       (rd_adr),
        .csr_adr      (csr_adr),
        .csr_wbk      (csr_wbk),
        .csr_clear    (csr_clear),
        .csrrw        (csrrw),
        .imm          (imm),
        .rs1_sel      (rs1_sel),
        .rs2_sel      (rs2_sel),
        .unsign_ext   (unsign_ext),
        .rs2_ca2_v    (rs2_ca2_v),
        .access_size  (access_size),
        .unit         (unit),
        .operation    (operation),
        .illegal_inst (illegal_inst)
    );

    assign rf_rs1_adr_o = rs1_adr;
    assign rf_rs2_adr_o = rs2_adr;
    assign csr_adr_o    = csr_adr;

    // Scan from the oldest source down so the youngest match overwrites.
    logic            rs1_hit, rs1_pend, rs2_hit, rs2_pend;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        rs1_hit  = 1'b0;
        rs1_pend = 1'b0;
        rs1_fwd  = '0;
        rs2_hit  = 1'b0;
        rs2_pend = 1'b0;
        rs2_fwd  = '0;
        for (int i = NB_FF - 1; i >= 0; i--) begin
            if (ff_v_i[i] && (ff_adr_i[i*5 +: 5] == rs1_adr)) begin
                rs1_hit  = 1'b1;
                rs1_pend = ff_pending_i[i];
                rs1_fwd  = ff_data_i[i*XLEN +: XLEN];
            end
            if (ff_v_i[i] && (ff_adr_i[i*5 +: 5] == rs2_adr)) begin
                rs2_hit  = 1'b1;
                rs2_pend = ff_pending_i[i];
                rs2_fwd  = ff_data_i[i*XLEN +: XLEN];
            end
        end
    end

    logic rs1_nz, rs2_nz, rs1_haz, rs2_haz, hazard, advance;

    assign rs1_nz  = (rs1_adr != 5'd0);
    assign rs2_nz  = (rs2_adr != 5'd0);
    assign rs1_haz = rs1_v & rs1_nz & rs1_hit & rs1_pend;
    assign rs2_haz = rs2_v & rs2_nz & rs2_hit & rs2_pend;
    assign hazard  = if_valid_i & (rs1_haz | rs2_haz);
    assign advance = ~valid_q_o | exe_ready_i;

    assign if_ready_o = advance & ~hazard & ~flush_v_i;

    // x0 never takes a forward: a producer targeting x0 writes nothing.
    logic [XLEN-1:0] rs1_reg, rs2_reg, csr_val, rs1_raw, rs2_raw, rs1_low;
    logic [XLEN:0]   rs1_op, rs2_ext, rs2_op;

    assign rs1_reg = (rs1_nz && rs1_hit) ? rs1_fwd : rf_rs1_data_i;
    assign rs2_reg = (rs2_nz && rs2_hit) ? rs2_fwd : rf_rs2_data_i;
    assign csr_val = (csr_ff_v_i && (csr_ff_adr_i == csr_adr)) ? csr_ff_data_i : csr_data_i;

    assign rs1_raw = (rs1_sel == 2'd2) ? pc_i    : (rs1_sel == 2'd1) ? imm : rs1_reg;
    assign rs2_raw = (rs2_sel == 2'd2) ? csr_val : (rs2_sel == 2'd1) ? imm : rs2_reg;

    // The extra top bit lets execute compare signed and unsigned with one adder.
    assign rs1_low = csr_clear ? ~rs1_raw : rs1_raw;
    assign rs1_op  = {~unsign_ext & rs1_raw[XLEN-1], rs1_low};
    assign rs2_ext = {~unsign_ext & rs2_raw[XLEN-1], rs2_raw};
    assign rs2_op  = rs2_ca2_v ? (~rs2_ext + (XLEN+1)'(1)) : rs2_ext;

    logic load;
    assign load = if_valid_i & ~hazard;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q_o        <= 1'b0;
            pc_q_o           <= '0;
            rd_v_q_o         <= 1'b0;
            rd_adr_q_o       <= '0;
            csr_wbk_q_o      <= 1'b0;
            csr_adr_q_o      <= '0;
            rs1_data_q_o     <= '0;
            rs2_data_q_o     <= '0;
            imm_q_o          <= '0;
            access_size_q_o  <= '0;
            unsign_ext_q_o   <= 1'b0;
            csrrw_q_o        <= 1'b0;
            unit_q_o         <= '0;
            operation_q_o    <= '0;
            illegal_inst_q_o <= 1'b0;
        end else if (flush_v_i) begin
            valid_q_o <= 1'b0;
        end else if (advance) begin
            valid_q_o <= load;
            if (load) begin
                pc_q_o           <= pc_i;
                rd_v_q_o         <= rd_v & ~illegal_inst;
                rd_adr_q_o       <= rd_adr;
                csr_wbk_q_o      <= csr_wbk & ~illegal_inst;
                csr_adr_q_o      <= csr_adr;
                rs1_data_q_o     <= rs1_op;
                rs2_data_q_o     <= rs2_op;
                imm_q_o          <= imm;
                access_size_q_o  <= access_size;
                unsign_ext_q_o   <= unsign_ext;
                csrrw_q_o        <= csrrw;
                unit_q_o         <= unit;
                operation_q_o    <= operation;
                illegal_inst_q_o <= illegal_inst;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_o <= '0;
        end else if (hazard && advance && !flush_v_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_dec_stage.sv
// tb/tb_dec_stage.sv - directed self-checking bench for dec_stage
module tb_dec_stage;
    localparam int XLEN  = 32;
    localparam int NB_FF = 2;

    localparam logic [31:0] I_ADD = 32'h006283B3;   // add x7,x5,x6
    localparam logic [31:0] I_SUB = 32'h401003B3;   // sub x7,x0,x1

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic                  if_valid, flush_v, exe_ready, csr_ff_v;
    logic [XLEN-1:0]       instr, pc, csr_data, csr_ff_data;
    logic [11:0]           csr_ff_adr;
    logic [NB_FF-1:0]      ff_v, ff_pend;
    logic [5*NB_FF-1:0]    ff_adr;
    logic [XLEN*NB_FF-1:0] ff_data;
    logic [XLEN-1:0]       rf [32];

    logic [4:0]      rs1_adr, rs2_adr, rs1_adr_2, rs2_adr_2;
    logic [XLEN-1:0] rs1_rd, rs2_rd, rs1_rd_2, rs2_rd_2;

    assign rs1_rd   = rf[rs1_adr];
    assign rs2_rd   = rf[rs2_adr];
    assign rs1_rd_2 = rf[rs1_adr_2];
    assign rs2_rd_2 = rf[rs2_adr_2];

    // main instance outputs
    logic            if_ready, valid_q, rd_v_q, csr_wbk_q, unsign_q, csrrw_q, illegal_q;
    logic [11:0]     csr_adr, csr_adr_q;
    logic [XLEN-1:0] pc_q, imm_q;
    logic [4:0]      rd_adr_q;
    logic [XLEN:0]   rs1_q, rs2_q;
    logic [2:0]      asize_q;
    logic [3:0]      unit_q, op_q;
    logic [15:0]     stall_cnt;

    // narrow-counter instance outputs
    logic            if_ready_2, valid_q_2, rd_v_q_2, csr_wbk_q_2, unsign_q_2, csrrw_q_2, illegal_q_2;
    logic [11:0]     csr_adr_2, csr_adr_q_2;
    logic [XLEN-1:0] pc_q_2, imm_q_2;
    logic [4:0]      rd_adr_q_2;
    logic [XLEN:0]   rs1_q_2, rs2_q_2;
    logic [2:0]      asize_q_2;
    logic [3:0]      unit_q_2, op_q_2;
    logic [1:0]      stall_cnt_2;

    dec_stage #(.XLEN(XLEN), .NB_FF(NB_FF), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .instr_i(instr), .pc_i(pc), .rf_rs1_adr_o(rs1_adr), .rf_rs2_adr_o(rs2_adr),
        .rf_rs1_data_i(rs1_rd), .rf_rs2_data_i(rs2_rd), .csr_adr_o(csr_adr), .csr_data_i(csr_data),
        .ff_v_i(ff_v), .ff_pending_i(ff_pend), .ff_adr_i(ff_adr), .ff_data_i(ff_data),
        .csr_ff_v_i(csr_ff_v), .csr_ff_adr_i(csr_ff_adr), .csr_ff_data_i(csr_ff_data),
        .exe_ready_i(exe_ready), .valid_q_o(valid_q), .pc_q_o(pc_q), .rd_v_q_o(rd_v_q),
        .rd_adr_q_o(rd_adr_q), .csr_wbk_q_o(csr_wbk_q), .csr_adr_q_o(csr_adr_q),
        .rs1_data_q_o(rs1_q), .rs2_data_q_o(rs2_q), .imm_q_o(imm_q), .access_size_q_o(asize_q),
        .unsign_ext_q_o(unsign_q), .csrrw_q_o(csrrw_q), .unit_q_o(unit_q), .operation_q_o(op_q),
        .illegal_inst_q_o(illegal_q), .stall_cnt_o(stall_cnt), .flush_v_i(flush_v)
    );

    dec_stage #(.XLEN(XLEN), .NB_FF(NB_FF), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .if_valid_i(if_valid), .if_ready_o(if_ready_2),
        .instr_i(instr), .pc_i(pc), .rf_rs1_adr_o(rs1_adr_2), .rf_rs2_adr_o(rs2_adr_2),
        .rf_rs1_data_i(rs1_rd_2), .rf_rs2_data_i(rs2_rd_2), .csr_adr_o(csr_adr_2), .csr_data_i(csr_data),
        .ff_v_i(ff_v), .ff_pending_i(ff_pend), .ff_adr_i(ff_adr), .ff_data_i(ff_data),
        .csr_ff_v_i(csr_ff_v), .csr_ff_adr_i(csr_ff_adr), .csr_ff_data_i(csr_ff_data),
        .exe_ready_i(exe_ready), .valid_q_o(valid_q_2), .pc_q_o(pc_q_2), .rd_v_q_o(rd_v_q_2),
        .rd_adr_q_o(rd_adr_q_2), .csr_wbk_q_o(csr_wbk_q_2), .csr_adr_q_o(csr_adr_q_2),
        .rs1_data_q_o(rs1_q_2), .rs2_data_q_o(rs2_q_2), .imm_q_o(imm_q_2), .access_size_q_o(asize_q_2),
        .unsign_ext_q_o(unsign_q_2), .csrrw_q_o(csrrw_q_2), .unit_q_o(unit_q_2), .operation_q_o(op_q_2),
        .illegal_inst_q_o(illegal_q_2), .stall_cnt_o(stall_cnt_2), .flush_v_i(flush_v)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        rf[1] = 32'h1;
        rf[5] = 32'h10;
        rf[6] = 32'h3;

        reset_n     = 1'b0;
        if_valid    = 1'b0;
        flush_v     = 1'b0;
        exe_ready   = 1'b1;
        instr       = '0;
        pc          = '0;
        csr_data    = '0;
        csr_ff_v    = 1'b0;
        csr_ff_adr  = '0;
        csr_ff_data = '0;
        ff_v        = '0;
        ff_pend     = '0;
        ff_adr      = '0;
        ff_data     = '0;

        // reset state
        #3;
        check("rst_valid", 64'(valid_q), 64'd0);
        check("rst_stall", 64'(stall_cnt), 64'd0);
        check("rst_stall2", 64'(stall_cnt_2), 64'd0);
        check("rst_rs1", 64'(rs1_q), 64'd0);
        check("rst_pc", 64'(pc_q), 64'd0);
        check("rst_imm", 64'(imm_q), 64'd0);
        tick();
        reset_n = 1'b1;

        // plain RF read
        if_valid = 1'b1;
        instr    = I_ADD;
        pc       = 32'h100;
        #1;
        check("rf_ready", 64'(if_ready), 64'd1);
        check("rf_rs1_adr", 64'(rs1_adr), 64'd5);
        check("rf_rs2_adr", 64'(rs2_adr), 64'd6);
        tick();
        check("rf_valid", 64'(valid_q), 64'd1);
        check("rf_rs1", 64'(rs1_q), 64'h10);
        check("rf_rs2", 64'(rs2_q), 64'h3);
        check("rf_rd_adr", 64'(rd_adr_q), 64'd7);
        check("rf_rd_v", 64'(rd_v_q), 64'd1);
        check("rf_pc", 64'(pc_q), 64'h100);

        // forwarding priority
        ff_v    = 2'b11;
        ff_adr  = {5'd5, 5'd5};
        ff_data = {32'hBB, 32'hAA};
        tick();
        check("fwd_prio_rs1", 64'(rs1_q), 64'hAA);
        check("fwd_prio_rs2", 64'(rs2_q), 64'h3);
        ff_v = 2'b10;
        tick();
        check("fwd_ff1_rs1", 64'(rs1_q), 64'hBB);

        // load-use stall for two cycles
        ff_v    = 2'b01;
        ff_adr  = {5'd0, 5'd5};
        ff_data = {32'h0, 32'h55};
        ff_pend = 2'b01;
        #1;
        check("lu_ready", 64'(if_ready), 64'd0);
        tick();
        check("lu_bubble1", 64'(valid_q), 64'd0);
        tick();
        check("lu_bubble2", 64'(valid_q), 64'd0);
        check("lu_stall", 64'(stall_cnt), 64'd2);
        check("lu_stall2", 64'(stall_cnt_2), 64'd2);
        ff_pend = 2'b00;
        #1;
        check("lu_resolve_ready", 64'(if_ready), 64'd1);
        tick();
        check("lu_valid", 64'(valid_q), 64'd1);
        check("lu_rs1", 64'(rs1_q), 64'h55);
        check("lu_stall_hold", 64'(stall_cnt), 64'd2);

        // x0 ignores a pending producer, SUB negates rs2
        instr   = I_SUB;
        pc      = 32'h104;
        ff_adr  = {5'd0, 5'd0};
        ff_data = {32'h0, 32'hFF};
        ff_pend = 2'b01;
        #1;
        check("x0_ready", 64'(if_ready), 64'd1);
        tick();
        check("x0_valid", 64'(valid_q), 64'd1);
        check("x0_rs1", 64'(rs1_q), 64'h0);
        check("sub_rs2", 64'(rs2_q), 64'h1_FFFF_FFFF);

        // backpressure holds the stage, then flush clears it
        exe_ready = 1'b0;
        instr     = I_ADD;
        pc        = 32'h200;
        ff_v      = 2'b00;
        ff_pend   = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_ready", 64'(if_ready), 64'd0);
            tick();
            check("bp_valid", 64'(valid_q), 64'd1);
            check("bp_rs2", 64'(rs2_q), 64'h1_FFFF_FFFF);
            check("bp_pc", 64'(pc_q), 64'h104);
        end
        flush_v = 1'b1;
        tick();
        check("bp_flush_valid", 64'(valid_q), 64'd0);
        check("bp_flush_payload", 64'(rs2_q), 64'h1_FFFF_FFFF);

        // accept, then flush with a valid instruction in the same cycle
        flush_v   = 1'b0;
        exe_ready = 1'b1;
        tick();
        check("acc_valid", 64'(valid_q), 64'd1);
        check("acc_pc", 64'(pc_q), 64'h200);
        flush_v = 1'b1;
        pc      = 32'h204;
        #1;
        check("fl_ready", 64'(if_ready), 64'd0);
        tick();
        check("fl_valid", 64'(valid_q), 64'd0);
        check("fl_pc", 64'(pc_q), 64'h200);

        // illegal instruction squashes writebacks but propagates
        flush_v = 1'b0;
        instr   = 32'h0;
        pc      = 32'h208;
        tick();
        check("ill_valid", 64'(valid_q), 64'd1);
        check("ill_flag", 64'(illegal_q), 64'd1);
        check("ill_rd_v", 64'(rd_v_q), 64'd0);
        check("ill_csr_wbk", 64'(csr_wbk_q), 64'd0);
        check("ill_pc", 64'(pc_q), 64'h208);

        // five more hazard cycles: 16-bit counter reaches 7, 2-bit counter saturates at 3
        instr   = I_ADD;
        ff_v    = 2'b01;
        ff_adr  = {5'd0, 5'd5};
        ff_pend = 2'b01;
        tick();
        check("sat_first", 64'(stall_cnt_2), 64'd3);
        for (int c = 0; c < 4; c++) tick();
        check("sat_valid", 64'(valid_q), 64'd0);
        check("sat_stall", 64'(stall_cnt), 64'd7);
        check("sat_stall2", 64'(stall_cnt_2), 64'd3);

        // asynchronous reset mid-operation
        #2;
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 64'(valid_q), 64'd0);
        check("mrst_stall", 64'(stall_cnt), 64'd0);
        check("mrst_stall2", 64'(stall_cnt_2), 64'd0);
        check("mrst_pc", 64'(pc_q), 64'd0);
        check("mrst_illegal", 64'(illegal_q), 64'd0);
        ff_v    = 2'b00;
        ff_pend = 2'b00;
        reset_n = 1'b1;
        #1;
        check("mrst_ready", 64'(if_ready), 64'd1);
        tick();
        check("mrst_accept", 64'(valid_q), 64'd1);
        check("mrst_rs1", 64'(rs1_q), 64'h10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dec_stage.md
# dec_stage

Parametrised successor of the decode stage. Sits between ifetch and execute, and instantiates the existing `decoder` unchanged. Adds a valid/ready handshake on both sides and N prioritised forwarding sources with load-use (pending) stall detection. Also adds x0 forwarding suppression, illegal-instruction squashing of writebacks and a saturating stall counter.

## Interface
Parameters:
- XLEN, 32, datapath width; operand outputs are XLEN+1 bits.
- NB_FF, 2, number of GPR forwarding sources; index 0 has highest priority (youngest).
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid_i  in  1  ifetch holds a valid instruction.
- if_ready_o  out  1  stage accepts the instruction this cycle.
- instr_i  in  XLEN  instruction word.
- pc_i  in  XLEN  instruction PC.
- rf_rs1_adr_o, rf_rs2_adr_o  out  5  RF read addresses (combinational from instr_i).
- rf_rs1_data_i, rf_rs2_data_i  in  XLEN  RF read data, same cycle.
- csr_adr_o  out  12  CSR read address; csr_data_i  in  XLEN  CSR read data.
- ff_v_i  in  NB_FF  source i will write a GPR.
- ff_pending_i  in  NB_FF  source i result not yet available (e.g. load in flight).
- ff_adr_i  in  5*NB_FF  destination of source i, packed (i*5 LSB).
- ff_data_i  in  XLEN*NB_FF  result of source i, packed.
- csr_ff_v_i  in  1  CSR forward valid; csr_ff_adr_i  in  12  CSR forward address; csr_ff_data_i  in  XLEN  CSR forward data.
- exe_ready_i  in  1  execute accepts the stage contents.
- valid_q_o  out  1  stage register holds a valid instruction.
- Payload outputs, all registered: pc_q_o (XLEN), rd_v_q_o (1), rd_adr_q_o (5), csr_wbk_q_o (1), csr_adr_q_o (12), rs1_data_q_o (XLEN+1), rs2_data_q_o (XLEN+1), imm_q_o (XLEN), access_size_q_o (3), unsign_ext_q_o (1), csrrw_q_o (1), unit_q_o (NB_UNIT), operation_q_o (NB_OPERATION), illegal_inst_q_o (1).
- stall_cnt_o  out  CNT_W  number of hazard-stall cycles, saturating.
- flush_v_i  in  1  pipeline flush.

## Operation
- Control signals:
  - advance = ~valid_q | exe_ready_i.
  - hazard = if_valid_i & (rs1_haz | rs2_haz).
  - if_ready_o = advance & ~hazard & ~flush_v_i.
- rsX_haz: rsX_v and rsX_adr≠0, and the lowest index i with ff_v_i[i] & ff_adr_i[i]==rsX_adr has ff_pending_i[i]=1.
- Forward select for rsX, evaluated only when rsX_adr≠0: the lowest matching non-pending source i supplies ff_data_i[i]. With no match, RF data is used. x0 always reads RF, never a forward.
- CSR operand: csr_ff_data_i when csr_ff_v_i & csr_ff_adr_i==csr_adr, otherwise csr_data_i.
- Operand rules (unchanged semantics from the decoder outputs):
  - rs1 = reg | imm | pc (auipc).
  - Bit XLEN = ~unsign_ext & bit XLEN-1.
  - The low XLEN bits are inverted when csr_clear.
  - rs2 = reg | imm | csr, extended the same way.
  - When rs2_ca2_v, rs2 = ~ext + 1, computed modulo 2^(XLEN+1).
- illegal_inst from the decoder: rd_v_q_o=0 and csr_wbk_q_o=0 are captured; the instruction still propagates with illegal_inst_q_o=1.
- Stage register update, in priority order:
  - flush_v_i: valid_q←0, payload unchanged.
  - else if advance: valid_q←if_valid_i & ~hazard, and payload is loaded when if_valid_i & ~hazard. Hazard with advance inserts a bubble.
  - else: hold everything.
- stall_cnt increments each cycle hazard & advance & ~flush_v_i, and saturates at all-ones.

## Timing
- Reset: valid_q_o=0, stall_cnt_o=0, and every payload output is 0.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Hazard resolution: when ff_pending_i drops, or the producer moves to a non-pending source, the instruction is accepted in that same cycle.
- Backpressure: with valid_q=1 & ~exe_ready_i, outputs are stable and if_ready_o=0. Forwarding for the held instruction was already resolved at capture; the stage register does not re-read operands.
- Flush with if_valid_i in the same cycle: the instruction is dropped, and valid_q_o=0 on the next cycle.
- Flush while stalled by backpressure: valid_q is cleared regardless of exe_ready_i.
- Reset mid-operation: asynchronous clear of all state; if_ready_o=1 after release.

## Test plan
- Plain RF read: RF x5=0x10, x6=0x3, instr ADD x7,x5,x6, no forwards -> next cycle valid_q_o=1, rs1_data_q_o=0x010, rs2_data_q_o=0x003, rd_adr_q_o=7.
- Priority forward: ff0 adr5 data 0xAA and ff1 adr5 data 0xBB, both non-pending -> rs1=0xAA. Repeat with ff0_v=0 -> rs1=0xBB.
- Load-use: ff0 adr5 pending for 2 cycles with ADD using x5 -> if_ready_o=0 and a bubble (valid_q_o=0) for 2 cycles, stall_cnt_o=2. Cycle 3 accepts with forwarded data.
- x0 and SUB: ff0 adr0 data 0xFF while rs1=x0 -> rs1=0. SUB with rs2=1 -> rs2_data_q_o=0x1_FFFF_FFFF.
- Backpressure and flush: hold exe_ready_i=0 for 3 cycles -> outputs stable, if_ready_o=0. Assert flush_v_i -> valid_q_o=0 next cycle.
- Illegal instruction 0x0000_0000 -> illegal_inst_q_o=1, rd_v_q_o=0, csr_wbk_q_o=0. Then CNT_W=2 with 5 hazard cycles -> stall_cnt_o=3.
